// File: rtl/payload_nfa_engine_if.sv
// payload_nfa_engine_if
//   Byte-stream bus between the shared character decoder and one NFA engine.
//   master : decoder side; drives en/class_in, observes the match outputs.
//   slave  : engine side; consumes en/class_in, drives the match outputs.
//   Signals:
//     en            byte valid for the current cycle
//     class_in      class hits for the current byte (one-hot or overlapping)
//     match         sticky match since last start of data
//     match_pulse   end state reached on the last enabled byte
//     match_cnt     saturating count of bytes completing a match
//     first_off     0-based offset of the byte completing the first match
//     first_off_vld first_off valid
interface payload_nfa_engine_if #(
  parameter int NUM_CLASSES = 42,
  parameter int CNT_W       = 8,
  parameter int OFF_W       = 16
);
  logic                   en;
  logic [NUM_CLASSES-1:0] class_in;
  logic                   match;
  logic                   match_pulse;
  logic [CNT_W-1:0]       match_cnt;
  logic [OFF_W-1:0]       first_off;
  logic                   first_off_vld;

  modport master (
    output en, class_in,
    input  match, match_pulse, match_cnt, first_off, first_off_vld
  );

  modport slave (
    input  en, class_in,
    output match, match_pulse, match_cnt, first_off, first_off_vld
  );
endinterface

// File: rtl/payload_nfa_engine.sv
// payload_nfa_engine
//   One NFA chain of NUM_STATES block states fed by the shared character
//   decoder. State i tracks "pattern elements 1..i matched, ending on the
//   last enabled byte"; a state with a self-loop stays alive while its class
//   keeps hitting (\s+, \d+ style). The last state drives the match outputs.
//   Optional macro PAYLOAD_NFA_MATCH_OFFSET_EN builds the byte offset
//   counter and the first-match offset capture; without it first_off and
//   first_off_vld are constant 0.
// Ports:
//   i_clk   rising-edge clock
//   i_sod   start of data; synchronous active-high reset of all state, wins
//           over en (a byte presented with sod is discarded)
//   nfa_if  slave side of payload_nfa_engine_if (en, class_in in;
//           match, match_pulse, match_cnt, first_off, first_off_vld out)
module payload_nfa_engine #(
  parameter int                          NUM_STATES  = 15,
  parameter int                          NUM_CLASSES = 42,
  parameter int                          CLS_W       = 6,
  parameter logic [NUM_STATES*CLS_W-1:0] CLS_MAP     = '0,
  parameter logic [NUM_STATES-1:0]       LOOP_MASK   = '0,
  parameter bit                          ANCHORED    = 1'b1,
  parameter int                          CNT_W       = 8,
  parameter int                          OFF_W       = 16
) (
  input logic                  i_clk,
  input logic                  i_sod,
  payload_nfa_engine_if.slave  nfa_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (NUM_STATES < 1 || NUM_STATES > 64) begin : g_bad_depth
    $error("payload_nfa_engine: NUM_STATES=%0d outside 1..64", NUM_STATES);
  end
  if ((2 ** CLS_W) < NUM_CLASSES) begin : g_bad_clsw
    $error("payload_nfa_engine: CLS_W=%0d too narrow for %0d classes", CLS_W, NUM_CLASSES);
  end

  logic [NUM_STATES:1] r_s;      // registered chain states s[1..N]
  logic [NUM_STATES:1] w_nxt;    // next value of every state
  logic                r_first;  // no enabled byte seen since sod
  logic                r_match;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_start;  // s[0]

  // Anchored patterns may only enter the chain on the first byte after sod.
  assign w_start = ANCHORED ? r_first : 1'b1;

  for (genvar i = 1; i <= NUM_STATES; i++) begin : g_state
    localparam int   CLS  = int'(CLS_MAP[(i-1)*CLS_W +: CLS_W]);
    localparam logic LOOP = LOOP_MASK[i-1];
    logic w_prev;

    if (i == 1) begin : g_head
      assign w_prev = w_start;
    end else begin : g_link
      assign w_prev = r_s[i-1];
    end

    if (CLS >= NUM_CLASSES) begin : g_bad_cls
      $error("payload_nfa_engine: state %0d class %0d >= NUM_CLASSES %0d", i, CLS, NUM_CLASSES);
    end else begin : g_ok
      assign w_nxt[i] = nfa_if.class_in[CLS] & (w_prev | (LOOP & r_s[i]));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sod) begin
      r_s     <= '0;
      r_first <= 1'b1;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else if (nfa_if.en) begin
      r_s     <= w_nxt;
      r_first <= 1'b0;
      // Folds in the registered end state, so match trails match_pulse by
      // one enabled byte (same latency as the legacy End_state).
      r_match <= r_match | r_s[NUM_STATES];
      if (w_nxt[NUM_STATES] && (r_cnt != CNT_MAX))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign nfa_if.match       = r_match;
  assign nfa_if.match_pulse = r_s[NUM_STATES];
  assign nfa_if.match_cnt   = r_cnt;

`ifdef PAYLOAD_NFA_MATCH_OFFSET_EN
  localparam logic [OFF_W-1:0] OFF_MAX = '1;

  // Offset of the byte currently on class_in; only the capture reads it,
  // so it lives with the capture logic.
  logic [OFF_W-1:0] r_byte_off;
  logic [OFF_W-1:0] r_first_off;
  logic             r_first_off_vld;

  always_ff @(posedge i_clk) begin
    if (i_sod) begin
      r_byte_off      <= '0;
      r_first_off     <= '0;
      r_first_off_vld <= 1'b0;
    end else if (nfa_if.en) begin
      if (r_byte_off != OFF_MAX)
        r_byte_off <= r_byte_off + 1'b1;
      if (w_nxt[NUM_STATES] && !r_first_off_vld) begin
        r_first_off     <= r_byte_off;
        r_first_off_vld <= 1'b1;
      end
    end
  end

  assign nfa_if.first_off     = r_first_off;
  assign nfa_if.first_off_vld = r_first_off_vld;
`else
  assign nfa_if.first_off     = {OFF_W{1'b0}};
  assign nfa_if.first_off_vld = 1'b0;
`endif

endmodule

// File: tb/tb_payload_nfa_engine.sv
// tb_payload_nfa_engine
//   Four engines share one byte stream:
//     u_dut0 "Mil"      classes 0,1,2  anchored
//     u_dut1 "Mil"      classes 0,1,2  unanchored
//     u_dut2 "a\s+b"    classes 0,3,1  loop on state 2, unanchored
//     u_dut3 "a+"       class 0        loop, unanchored, CNT_W=2, OFF_W=3
//   A reference model judges each enabled byte as a pattern match over the
//   recorded byte history since sod (explicit start offsets), and every
//   output of every engine is compared after each clock edge.
module tb_payload_nfa_engine;

  localparam int NC   = 8;
  localparam int ND   = 4;
  localparam int HMAX = 64;
`ifdef PAYLOAD_NFA_MATCH_OFFSET_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  logic          clk;
  logic          tb_sod;
  logic          tb_en;
  logic [NC-1:0] tb_cls;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  payload_nfa_engine_if #(.NUM_CLASSES(NC), .CNT_W(8), .OFF_W(16)) if0 ();
  payload_nfa_engine_if #(.NUM_CLASSES(NC), .CNT_W(8), .OFF_W(16)) if1 ();
  payload_nfa_engine_if #(.NUM_CLASSES(NC), .CNT_W(8), .OFF_W(16)) if2 ();
  payload_nfa_engine_if #(.NUM_CLASSES(NC), .CNT_W(2), .OFF_W(3))  if3 ();

  assign if0.en = tb_en;  assign if0.class_in = tb_cls;
  assign if1.en = tb_en;  assign if1.class_in = tb_cls;
  assign if2.en = tb_en;  assign if2.class_in = tb_cls;
  assign if3.en = tb_en;  assign if3.class_in = tb_cls;

  payload_nfa_engine #(.NUM_STATES(3), .NUM_CLASSES(NC), .CLS_W(3), .CLS_MAP(9'b010_001_000),
    .LOOP_MASK(3'b000), .ANCHORED(1'b1), .CNT_W(8), .OFF_W(16))
    u_dut0 (.i_clk(clk), .i_sod(tb_sod), .nfa_if(if0));
  payload_nfa_engine #(.NUM_STATES(3), .NUM_CLASSES(NC), .CLS_W(3), .CLS_MAP(9'b010_001_000),
    .LOOP_MASK(3'b000), .ANCHORED(1'b0), .CNT_W(8), .OFF_W(16))
    u_dut1 (.i_clk(clk), .i_sod(tb_sod), .nfa_if(if1));
  payload_nfa_engine #(.NUM_STATES(3), .NUM_CLASSES(NC), .CLS_W(3), .CLS_MAP(9'b001_011_000),
    .LOOP_MASK(3'b010), .ANCHORED(1'b0), .CNT_W(8), .OFF_W(16))
    u_dut2 (.i_clk(clk), .i_sod(tb_sod), .nfa_if(if2));
  payload_nfa_engine #(.NUM_STATES(1), .NUM_CLASSES(NC), .CLS_W(3), .CLS_MAP(3'b000),
    .LOOP_MASK(1'b1), .ANCHORED(1'b0), .CNT_W(2), .OFF_W(3))
    u_dut3 (.i_clk(clk), .i_sod(tb_sod), .nfa_if(if3));

  logic [31:0] o_pulse [ND];
  logic [31:0] o_match [ND];
  logic [31:0] o_cnt   [ND];
  logic [31:0] o_off   [ND];
  logic [31:0] o_vld   [ND];

  assign o_pulse[0] = 32'(if0.match_pulse); assign o_match[0] = 32'(if0.match);
  assign o_cnt[0]   = 32'(if0.match_cnt);   assign o_off[0]   = 32'(if0.first_off);
  assign o_vld[0]   = 32'(if0.first_off_vld);
  assign o_pulse[1] = 32'(if1.match_pulse); assign o_match[1] = 32'(if1.match);
  assign o_cnt[1]   = 32'(if1.match_cnt);   assign o_off[1]   = 32'(if1.first_off);
  assign o_vld[1]   = 32'(if1.first_off_vld);
  assign o_pulse[2] = 32'(if2.match_pulse); assign o_match[2] = 32'(if2.match);
  assign o_cnt[2]   = 32'(if2.match_cnt);   assign o_off[2]   = 32'(if2.first_off);
  assign o_vld[2]   = 32'(if2.first_off_vld);
  assign o_pulse[3] = 32'(if3.match_pulse); assign o_match[3] = 32'(if3.match);
  assign o_cnt[3]   = 32'(if3.match_cnt);   assign o_off[3]   = 32'(if3.first_off);
  assign o_vld[3]   = 32'(if3.first_off_vld);

  // Pattern description per engine (element e = state e+1).
  int cfg_n    [ND]    = '{3, 3, 3, 1};
  int cfg_cls  [ND][3] = '{'{0, 1, 2}, '{0, 1, 2}, '{0, 3, 1}, '{0, 0, 0}};
  bit cfg_loop [ND][3] = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 1, 0}, '{1, 0, 0}};
  bit cfg_anc  [ND]    = '{1, 0, 0, 0};
  int cfg_cmax [ND]    = '{255, 255, 255, 3};
  int cfg_omax [ND]    = '{65535, 65535, 65535, 7};

  // Model state.
  logic [NC-1:0] hist [HMAX];
  int k;                  // enabled bytes since sod
  int m_pulse [ND];
  int m_match [ND];
  int m_cnt   [ND];
  int m_off   [ND];
  int m_vld   [ND];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // True when history bytes j..kk spell the pattern of engine d exactly:
  // each plain element takes one byte, each looped element a run of >=1.
  function automatic bit span_match(int d, int j, int kk);
    bit t [4][HMAX];  // t[e][p]: bytes j..p consumed by elements 1..e
    bool_init: for (int e = 0; e < 4; e++)
      for (int p = 0; p < HMAX; p++) t[e][p] = 1'b0;
    for (int p = j; p <= kk; p++) begin
      for (int e = 1; e <= cfg_n[d]; e++) begin
        bit via;
        if (p == j) via = (e == 1);
        else via = t[e-1][p-1] || (cfg_loop[d][e-1] && t[e][p-1]);
        t[e][p] = hist[p][cfg_cls[d][e-1]] && via;
      end
    end
    return t[cfg_n[d]][kk];
  endfunction

  task automatic model_edge(input bit sod, input bit en, input logic [NC-1:0] cls);
    if (sod) begin
      k = 0;
      for (int d = 0; d < ND; d++) begin
        m_pulse[d] = 0; m_match[d] = 0; m_cnt[d] = 0; m_off[d] = 0; m_vld[d] = 0;
      end
    end else if (en) begin
      hist[k] = cls;
      for (int d = 0; d < ND; d++) begin
        bit hit;
        hit = 1'b0;
        for (int j = 0; j <= (cfg_anc[d] ? 0 : k); j++)
          if (span_match(d, j, k)) hit = 1'b1;
        m_match[d] = (m_match[d] != 0 || m_pulse[d] != 0) ? 1 : 0;
        m_pulse[d] = hit ? 1 : 0;
        if (hit && m_cnt[d] < cfg_cmax[d]) m_cnt[d]++;
        if (OFF_EN && hit && m_vld[d] == 0) begin
          m_off[d] = (k > cfg_omax[d]) ? cfg_omax[d] : k;
          m_vld[d] = 1;
        end
      end
      k++;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("pulse%0d", d), o_pulse[d], m_pulse[d]);
      chk($sformatf("match%0d", d), o_match[d], m_match[d]);
      chk($sformatf("cnt%0d", d),   o_cnt[d],   m_cnt[d]);
      chk($sformatf("off%0d", d),   o_off[d],   m_off[d]);
      chk($sformatf("vld%0d", d),   o_vld[d],   m_vld[d]);
    end
  endtask

  task automatic step(input bit sod, input bit en, input logic [NC-1:0] cls);
    @(negedge clk);
    tb_sod = sod; tb_en = en; tb_cls = cls;
    @(posedge clk);
    model_edge(sod, en, cls);
    #1;
    check_all();
  endtask

  // Symbols: 0 = M/a, 1 = i/b, 2 = l, 3 = space, 4..7 = other.
  task automatic feed(input int sym);
    step(1'b0, 1'b1, NC'(1) << sym);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, NC'($urandom()));
  endtask

  int            q[$];
  int            r;
  int            sym;
  bit            sd;
  bit            e;
  logic [NC-1:0] cv;

  initial begin
    tb_sod = 1'b1; tb_en = 1'b0; tb_cls = '0;
    k = 0;

    // Reset state
    step(1'b1, 1'b0, '0);
    chk("rst_match", o_match[0], 0);
    chk("rst_cnt", o_cnt[0], 0);

    // T1 "Mil"
    step(1'b1, 1'b0, '0);
    feed(0); feed(1); feed(2);
    chk("T1_pulse", o_pulse[0], 1);
    chk("T1_match_early", o_match[0], 0);
    feed(4);
    chk("T1_match", o_match[0], 1);
    chk("T1_cnt", o_cnt[0], 1);

    // T2 anchoring: x,M,i,l
    step(1'b1, 1'b0, '0);
    feed(4); feed(0); feed(1); feed(2); feed(4);
    chk("T2_anc_match", o_match[0], 0);
    chk("T2_anc_cnt", o_cnt[0], 0);
    chk("T2_una_match", o_match[1], 1);
    chk("T2_una_off", o_off[1], OFF_EN ? 3 : 0);

    // T3 loop: a,sp,sp,sp,b then a,b
    step(1'b1, 1'b0, '0);
    feed(0); feed(3); feed(3); feed(3); feed(1); feed(4);
    chk("T3_match", o_match[2], 1);
    chk("T3_off", o_off[2], OFF_EN ? 4 : 0);
    step(1'b1, 1'b0, '0);
    feed(0); feed(1); feed(4);
    chk("T3_nomatch", o_match[2], 0);

    // T4 en gaps with garbage on class_in
    step(1'b1, 1'b0, '0);
    feed(0); idle(3); feed(1); idle(3); feed(2); idle(3);
    chk("T4_pulse", o_pulse[0], 1);
    feed(4);
    chk("T4_match", o_match[0], 1);
    chk("T4_cnt", o_cnt[0], 1);

    // T5 sod mid-stream discards the byte it arrives with
    step(1'b1, 1'b0, '0);
    feed(0); feed(1);
    step(1'b1, 1'b1, NC'(1) << 2);
    chk("T5_pulse", o_pulse[0], 0);
    feed(2); feed(4);
    chk("T5_match", o_match[0], 0);
    chk("T5_cnt", o_cnt[1], 0);

    // T6 saturation of a 2-bit counter
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) feed(0);
    chk("T6_cnt", o_cnt[3], 3);
    chk("T6_vld", o_vld[3], OFF_EN ? 1 : 0);

    // T7 first match past the saturated 3-bit offset
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 9; i++) feed(4);
    feed(0);
    chk("T7_off", o_off[3], OFF_EN ? 7 : 0);

    // Random stream with injected pattern bursts
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 1500; c++) begin
      sd = ($urandom_range(0, 59) == 0) || (k >= 40);
      e  = ($urandom_range(0, 3) != 0);
      if (e && !sd) begin
        if (q.size() == 0) begin
          r = $urandom_range(0, 9);
          if (r == 0)      q = '{0, 1, 2};
          else if (r == 1) q = '{0, 3, 3, 1};
          else if (r == 2) q = '{0, 0, 0};
          else             q.push_back($urandom_range(0, 5));
        end
        sym = q.pop_front();
      end else begin
        sym = $urandom_range(0, 7);
      end
      cv = NC'(1) << sym;
      if ($urandom_range(0, 7) == 0) cv = cv | NC'($urandom());
      step(sd, e, cv);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
